stopwatch_lap: RTL and testbench
================================

STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000000, clk cycles per centisecond tick (>=2).
REQ-002 SHALL have parameter LAP_DEPTH, default 8, lap FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port toggle  input  1  start/stop level; each rising edge is one toggle event.
REQ-006 SHALL have port clear  input  1  single-cycle pulse, zeroes count when not running.
REQ-007 SHALL have port lap  input  1  single-cycle pulse, captures current time into lap FIFO.
REQ-008 SHALL have port lap_rd  input  1  single-cycle pulse, pops lap FIFO head.
REQ-009 SHALL have port disp_time  output  24  BCD MM:SS:CC, [23:20] min tens ... [3:0] centisecond units.
REQ-010 SHALL have port running  output  1  high in RUN state.
REQ-011 SHALL have port wrapped  output  1  sticky, set on 59:59:99 -> 00:00:00 rollover.
REQ-012 SHALL have ports lap_time  output  24  FIFO head; lap_empty  output  1; lap_full  output  1; lap_ovf  output  1  sticky dropped-capture flag.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE.
REQ-014 SHALL detect toggle rising edge via a registered copy; event takes effect the cycle after the edge is sampled.
REQ-015 SHALL transition on toggle event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 SHALL on clear in PAUSE or IDLE zero disp_time, clear wrapped, enter IDLE; clear in RUN ignored.
REQ-017 SHALL give toggle event priority over clear in the same cycle.
REQ-018 SHALL run a prescaler 0..CLK_DIV-1 only in RUN; terminal count issues a one-cycle tick and wraps to 0.
REQ-019 SHALL hold prescaler value in PAUSE; zero it on IDLE entry.
REQ-020 SHALL advance count by 0.01 s per tick with BCD digit moduli 10,10 | 10,6 | 10,6 (CC, SS, MM), carries rippling same cycle.
REQ-021 SHALL roll 59:59:99 to 00:00:00 on tick, set wrapped, keep running.
REQ-022 SHALL never present a non-BCD digit or a seconds/minutes tens digit above 5 on disp_time.
REQ-023 SHALL on lap in RUN push the pre-tick count (value on disp_time that cycle); lap outside RUN ignored.
REQ-024 SHALL drop a push when full without pop, set lap_ovf; push and pop together when full both succeed.
REQ-025 SHALL ignore lap_rd when empty; lap_time SHALL be don't-care-free: 0 when empty.
REQ-026 SHALL show a pushed entry on lap_time the cycle after push (when FIFO was empty).
REQ-027 SHALL clear lap FIFO and lap_ovf on clear that enters IDLE.

Reset
REQ-028 SHALL on reset: state IDLE, prescaler 0, disp_time 0, running 0, wrapped 0, FIFO empty, lap_empty 1, lap_full 0, lap_ovf 0, lap_time 0, edge register 0.
REQ-029 SHALL let reset override every other input including mid-run and mid-FIFO operation.

Configuration
REQ-030 SHALL compile lap FIFO only when STOPWATCH_LAP_EN is defined.
REQ-031 SHALL without STOPWATCH_LAP_EN keep all ports, ignore lap/lap_rd, tie lap_time 0, lap_empty 1, lap_full 0, lap_ovf 0.

Structure
REQ-032 SHALL place state enum, BCD digit width (4), digit moduli and TIME_W (24) in package stopwatch_pkg.
REQ-033 SHALL use sub-module bcd_digit_counter (parameter MODULUS; inputs clk, reset, clr, inc; outputs digit, carry), instantiated six times.

Verification (CLK_DIV=2, LAP_DEPTH=4)
REQ-034 SHALL cover: reset, toggle rise, 200 clk -> disp_time 0x000100, running 1.
REQ-035 SHALL cover: preload-by-run to 0x595999, one tick -> disp_time 0x000000, wrapped 1, running 1.
REQ-036 SHALL cover: RUN, toggle rise (PAUSE), 50 clk -> disp_time unchanged; toggle rise -> resumes with held prescaler.
REQ-037 SHALL cover: 5 lap pulses in RUN at distinct times -> lap_full 1, lap_ovf 1, four lap_rd return first four captures in order, then lap_empty 1.
REQ-038 SHALL cover: clear in RUN -> no effect; clear in PAUSE -> disp_time 0, IDLE, FIFO empty, wrapped 0.
REQ-039 SHALL cover: reset asserted mid-RUN with FIFO non-empty -> all outputs at REQ-028 values next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch_lap block: FSM states, BCD digit
// geometry and per-digit moduli (CC units/tens, SS units/tens, MM units/tens).
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_e;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned TIME_W  = 24;

   localparam int unsigned CC0_MOD = 10;
   localparam int unsigned CC1_MOD = 10;
   localparam int unsigned SS0_MOD = 10;
   localparam int unsigned SS1_MOD = 6;
   localparam int unsigned MM0_MOD = 10;
   localparam int unsigned MM1_MOD = 6;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with configurable modulus; carry is combinational so a chain of
// digits ripples a full rollover within a single clock.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MODULUS = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry
);

   logic [DIGIT_W-1:0] digit_q, digit_d;
   logic               at_top;

   always_comb begin
      // >= rather than == so an out-of-range value can never persist
      at_top  = (digit_q >= DIGIT_W'(MODULUS - 1));
      carry   = inc & at_top;
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (inc) begin
         digit_d = at_top ? '0 : digit_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;

endmodule

// File: rtl/stopwatch_lap.sv
// MM:SS:CC BCD stopwatch with start/stop/clear control and an optional lap FIFO,
// compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_lap
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 1000000,
   parameter int unsigned LAP_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              toggle,
   input  logic              clear,
   input  logic              lap,
   input  logic              lap_rd,
   output logic [TIME_W-1:0] disp_time,
   output logic              running,
   output logic              wrapped,
   output logic [TIME_W-1:0] lap_time,
   output logic              lap_empty,
   output logic              lap_full,
   output logic              lap_ovf
);

   localparam int unsigned PRESC_W = $clog2(CLK_DIV);

   sw_state_e           state_q, state_d;
   logic                toggle_q;
   logic                running_q, running_d;
   logic                wrapped_q, wrapped_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic                toggle_evt, clr_go, tick;
   logic [5:0]          carry;
   logic [TIME_W-1:0]   time_w;

   assign toggle_evt = toggle & ~toggle_q;
   assign tick       = (state_q == ST_RUN) && (presc_q == PRESC_W'(CLK_DIV - 1));

   always_comb begin
      state_d = state_q;
      clr_go  = 1'b0;
      if (toggle_evt) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end else if (clear && (state_q != ST_RUN)) begin
         state_d = ST_IDLE;
         clr_go  = 1'b1;
      end
      running_d = (state_d == ST_RUN);

      presc_d = presc_q;
      if (clr_go) begin
         presc_d = '0;
      end else if (state_q == ST_RUN) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      wrapped_d = clr_go ? 1'b0 : (wrapped_q | carry[5]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         toggle_q  <= 1'b0;
         running_q <= 1'b0;
         wrapped_q <= 1'b0;
         presc_q   <= '0;
      end else begin
         state_q   <= state_d;
         toggle_q  <= toggle;
         running_q <= running_d;
         wrapped_q <= wrapped_d;
         presc_q   <= presc_d;
      end
   end

   bcd_digit_counter #(.MODULUS(CC0_MOD)) u_cc0 (
      .clk(clk), .reset(reset), .clr(clr_go), .inc(tick),
      .digit(time_w[3:0]), .carry(carry[0]));
   bcd_digit_counter #(.MODULUS(CC1_MOD)) u_cc1 (
      .clk(clk), .reset(reset), .clr(clr_go), .inc(carry[0]),
      .digit(time_w[7:4]), .carry(carry[1]));
   bcd_digit_counter #(.MODULUS(SS0_MOD)) u_ss0 (
      .clk(clk), .reset(reset), .clr(clr_go), .inc(carry[1]),
      .digit(time_w[11:8]), .carry(carry[2]));
   bcd_digit_counter #(.MODULUS(SS1_MOD)) u_ss1 (
      .clk(clk), .reset(reset), .clr(clr_go), .inc(carry[2]),
      .digit(time_w[15:12]), .carry(carry[3]));
   bcd_digit_counter #(.MODULUS(MM0_MOD)) u_mm0 (
      .clk(clk), .reset(reset), .clr(clr_go), .inc(carry[3]),
      .digit(time_w[19:16]), .carry(carry[4]));
   bcd_digit_counter #(.MODULUS(MM1_MOD)) u_mm1 (
      .clk(clk), .reset(reset), .clr(clr_go), .inc(carry[4]),
      .digit(time_w[23:20]), .carry(carry[5]));

   assign disp_time = time_w;
   assign running   = running_q;
   assign wrapped   = wrapped_q;

`ifdef STOPWATCH_LAP_EN
   localparam int unsigned PTR_W = $clog2(LAP_DEPTH);

   logic [TIME_W-1:0] mem_q [LAP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              push, pop, push_ok, fifo_empty, fifo_full;

   always_comb begin
      fifo_empty = (cnt_q == '0);
      fifo_full  = (cnt_q == (PTR_W + 1)'(LAP_DEPTH));
      pop        = lap_rd & ~fifo_empty;
      push       = lap & (state_q == ST_RUN);
      // a full FIFO still accepts a capture when the head leaves the same cycle
      push_ok    = push & (~fifo_full | pop);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q | (push & ~push_ok);
      if (clr_go) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem_q[wr_ptr_q] <= time_w;
      end
   end

   assign lap_time  = fifo_empty ? '0 : mem_q[rd_ptr_q];
   assign lap_empty = fifo_empty;
   assign lap_full  = fifo_full;
   assign lap_ovf   = ovf_q;
`else
   logic unused_lap;
   assign unused_lap = lap ^ lap_rd ^ (LAP_DEPTH > 1);

   assign lap_time  = '0;
   assign lap_empty = 1'b1;
   assign lap_full  = 1'b0;
   assign lap_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap at CLK_DIV=2, LAP_DEPTH=4; lap expectations
// follow whichever build (STOPWATCH_LAP_EN defined or not) is compiled.
module tb_stopwatch_lap;

`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, toggle, clear, lap, lap_rd;
   logic [23:0] disp_time, lap_time;
   logic        running, wrapped, lap_empty, lap_full, lap_ovf;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   always #5 clk = ~clk;

   stopwatch_lap #(.CLK_DIV(2), .LAP_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .toggle(toggle), .clear(clear),
      .lap(lap), .lap_rd(lap_rd), .disp_time(disp_time), .running(running),
      .wrapped(wrapped), .lap_time(lap_time), .lap_empty(lap_empty),
      .lap_full(lap_full), .lap_ovf(lap_ovf));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic toggle_rise();
      toggle = 1'b1;
      cyc(1);
      toggle = 1'b0;
   endtask

   function automatic logic [23:0] exp_lt(input logic [23:0] v);
      return LAP_EN ? v : 24'h0;
   endfunction
   function automatic logic exp_le(input logic v);
      return LAP_EN ? v : 1'b1;
   endfunction
   function automatic logic exp_lf(input logic v);
      return LAP_EN ? v : 1'b0;
   endfunction

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_disp"},  32'(disp_time), 32'h0);
      check_eq({tag, "_run"},   32'(running),   32'h0);
      check_eq({tag, "_wrap"},  32'(wrapped),   32'h0);
      check_eq({tag, "_lt"},    32'(lap_time),  32'h0);
      check_eq({tag, "_empty"}, 32'(lap_empty), 32'h1);
      check_eq({tag, "_full"},  32'(lap_full),  32'h0);
      check_eq({tag, "_ovf"},   32'(lap_ovf),   32'h0);
   endtask

   initial begin
      reset = 1'b1; toggle = 1'b0; clear = 1'b0; lap = 1'b0; lap_rd = 1'b0;
      cyc(2);
      check_reset_state("rst");
      reset = 1'b0;
      cyc(1);

      // start: tick on every second edge after the RUN edge, 100 ticks = 1.00 s
      toggle_rise();
      check_eq("start_run", 32'(running), 32'h1);
      check_eq("start_disp", 32'(disp_time), 32'h0);
      cyc(200);
      check_eq("one_sec", 32'(disp_time), 32'h000100);

      // pause holds display and prescaler (prescaler is 1 when paused here)
      toggle_rise();
      check_eq("pause_run", 32'(running), 32'h0);
      cyc(50);
      check_eq("pause_hold", 32'(disp_time), 32'h000100);
      toggle_rise();
      check_eq("resume_run", 32'(running), 32'h1);
      cyc(1);
      check_eq("resume_tick", 32'(disp_time), 32'h000101);
      cyc(2);
      check_eq("resume_next", 32'(disp_time), 32'h000102);

      // five laps, three edges apart: captures 102,103,105,106; fifth dropped
      lap = 1'b1; cyc(1); lap = 1'b0;
      check_eq("lap1_head", 32'(lap_time), 32'(exp_lt(24'h000102)));
      check_eq("lap1_empty", 32'(lap_empty), 32'(exp_le(1'b0)));
      cyc(2);
      lap = 1'b1; cyc(1); lap = 1'b0; cyc(2);
      lap = 1'b1; cyc(1); lap = 1'b0; cyc(2);
      lap = 1'b1; cyc(1); lap = 1'b0;
      check_eq("lap4_full", 32'(lap_full), 32'(exp_lf(1'b1)));
      check_eq("lap4_ovf", 32'(lap_ovf), 32'h0);
      cyc(2);
      lap = 1'b1; cyc(1); lap = 1'b0;
      check_eq("lap5_ovf", 32'(lap_ovf), 32'(exp_lf(1'b1)));
      check_eq("lap5_full", 32'(lap_full), 32'(exp_lf(1'b1)));
      check_eq("lap5_head", 32'(lap_time), 32'(exp_lt(24'h000102)));

      check_eq("rd0", 32'(lap_time), 32'(exp_lt(24'h000102)));
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
      check_eq("rd1", 32'(lap_time), 32'(exp_lt(24'h000103)));
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
      check_eq("rd2", 32'(lap_time), 32'(exp_lt(24'h000105)));
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
      check_eq("rd3", 32'(lap_time), 32'(exp_lt(24'h000106)));
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
      check_eq("rd_empty", 32'(lap_empty), 32'h1);
      check_eq("rd_empty_lt", 32'(lap_time), 32'h0);
      check_eq("rd_not_full", 32'(lap_full), 32'h0);
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
      check_eq("rd_extra_empty", 32'(lap_empty), 32'h1);
      check_eq("ovf_sticky", 32'(lap_ovf), 32'(exp_lf(1'b1)));

      // clear in RUN ignored; clear in PAUSE zeroes everything
      lap = 1'b1; cyc(1); lap = 1'b0;
      clear = 1'b1; cyc(1); clear = 1'b0;
      check_eq("clr_run_run", 32'(running), 32'h1);
      check_eq("clr_run_empty", 32'(lap_empty), 32'(exp_le(1'b0)));
      check_eq("clr_run_ovf", 32'(lap_ovf), 32'(exp_lf(1'b1)));
      toggle_rise();
      cyc(3);
      clear = 1'b1; cyc(1); clear = 1'b0;
      check_eq("clr_pause_disp", 32'(disp_time), 32'h0);
      check_eq("clr_pause_run", 32'(running), 32'h0);
      check_eq("clr_pause_empty", 32'(lap_empty), 32'h1);
      check_eq("clr_pause_ovf", 32'(lap_ovf), 32'h0);
      cyc(4);
      check_eq("idle_hold", 32'(disp_time), 32'h0);

      // rollover: preload 59:59:99 in IDLE, start, release before the first tick
      force dut.u_cc0.digit_q = 4'd9;
      force dut.u_cc1.digit_q = 4'd9;
      force dut.u_ss0.digit_q = 4'd9;
      force dut.u_ss1.digit_q = 4'd5;
      force dut.u_mm0.digit_q = 4'd9;
      force dut.u_mm1.digit_q = 4'd5;
      toggle_rise();
      cyc(1);
      release dut.u_cc0.digit_q;
      release dut.u_cc1.digit_q;
      release dut.u_ss0.digit_q;
      release dut.u_ss1.digit_q;
      release dut.u_mm0.digit_q;
      release dut.u_mm1.digit_q;
      check_eq("pre_wrap", 32'(disp_time), 32'h595999);
      cyc(1);
      check_eq("wrap_disp", 32'(disp_time), 32'h0);
      check_eq("wrap_flag", 32'(wrapped), 32'h1);
      check_eq("wrap_run", 32'(running), 32'h1);
      cyc(2);
      check_eq("wrap_next", 32'(disp_time), 32'h000001);
      check_eq("wrap_sticky", 32'(wrapped), 32'h1);
      toggle_rise();
      clear = 1'b1; cyc(1); clear = 1'b0;
      check_eq("wrap_clr_flag", 32'(wrapped), 32'h0);
      check_eq("wrap_clr_disp", 32'(disp_time), 32'h0);

      // toggle and clear together in IDLE: toggle wins, enters RUN
      toggle = 1'b1; clear = 1'b1; cyc(1); toggle = 1'b0; clear = 1'b0;
      check_eq("tog_prio_run", 32'(running), 32'h1);

      // reset mid-run with FIFO occupied
      cyc(5);
      lap = 1'b1; cyc(1); lap = 1'b0;
      check_eq("pre_rst_empty", 32'(lap_empty), 32'(exp_le(1'b0)));
      reset = 1'b1; lap = 1'b1; cyc(1); lap = 1'b0;
      check_reset_state("midrst");
      reset = 1'b0;
      cyc(3);
      check_eq("post_rst_disp", 32'(disp_time), 32'h0);
      check_eq("post_rst_run", 32'(running), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
